// File: rtl/jpc_pkg.sv
// Definitions shared by the fetch front end and the later stages that compare
// redirect epochs: PC-generator state encoding, address width, step, epoch width.
package jpc_pkg;

    localparam int JPC_ADDRESS_WIDTH = 32;
    localparam logic [JPC_ADDRESS_WIDTH-1:0] JPC_NULL_ADDRESS = '0;
    localparam int JPC_PC_STEP       = 4;
    localparam int JPC_EPOCH_WIDTH   = 2;
    localparam int JPC_COUNT_WIDTH   = 32;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2,
        FAULT  = 2'd3
    } pcgen_state_e;

    // Epoch after a redirect; wraps naturally at the tag width.
    function automatic logic [JPC_EPOCH_WIDTH-1:0] epoch_advance(
        input logic [JPC_EPOCH_WIDTH-1:0] epoch
    );
        return epoch + JPC_EPOCH_WIDTH'(1);
    endfunction

endpackage

// File: rtl/jpc_counter.sv
// Free-running event counter with synchronous clear; wraps at 2^WIDTH.
module jpc_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (inc) begin
            count_reg <= count_reg + WIDTH'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/jpc_pcgen.sv
// Program-counter generator feeding jpc_ifetch: sequential fetch addresses,
// epoch-tagged redirects, halt/resume, sticky misaligned-redirect fault.
module jpc_pcgen
    import jpc_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = JPC_ADDRESS_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = JPC_NULL_ADDRESS,
    parameter int                    PC_STEP     = JPC_PC_STEP,
    parameter int                    EPOCH_WIDTH = JPC_EPOCH_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [ADDR_WIDTH-1:0]  pc_O,
    output logic                   pc_valid_O,
    input  logic                   pc_ready_I,
    output logic [EPOCH_WIDTH-1:0] epoch_O,
    input  logic                   redirect_valid_I,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc_I,
    input  logic                   halt_I,
    output logic                   misalign_O,
    output logic [31:0]            issued_count_O
);

    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(PC_STEP);

    pcgen_state_e           state_reg, state_next;
    logic [ADDR_WIDTH-1:0]  pc_reg, pc_next;
    logic [EPOCH_WIDTH-1:0] epoch_reg, epoch_next;
    logic                   valid_reg, valid_next;
    logic                   misalign_reg, misalign_next;

    logic handshake;
    logic redirect_take;
    logic target_misaligned;

    assign handshake         = valid_reg & pc_ready_I;
    assign redirect_take     = redirect_valid_I && (state_reg != FAULT);
    assign target_misaligned = (redirect_pc_I % STEP) != '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= BOOT;
            pc_reg       <= RESET_PC;
            epoch_reg    <= '0;
            valid_reg    <= 1'b0;
            misalign_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            epoch_reg    <= epoch_next;
            valid_reg    <= valid_next;
            misalign_reg <= misalign_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        epoch_next    = epoch_reg;
        misalign_next = misalign_reg;

        // A redirect flushes the offer; the old PC may still have been accepted
        // this cycle, which only the counter sees.
        if (redirect_take) begin
            pc_next    = redirect_pc_I;
            epoch_next = epoch_reg + EPOCH_WIDTH'(1);
        end else if (handshake) begin
            pc_next = pc_reg + STEP;
        end

        case (state_reg)
            BOOT, RUN, HALTED: begin
                if (redirect_take && target_misaligned) begin
                    state_next    = FAULT;
                    misalign_next = 1'b1;
                end else if (halt_I) begin
                    state_next = HALTED;
                end else begin
                    state_next = RUN;
                end
            end
            FAULT:   state_next = FAULT;
            default: state_next = BOOT;
        endcase

        // Valid is registered from the next state so it tracks RUN exactly.
        valid_next = (state_next == RUN);
    end

    jpc_counter #(
        .WIDTH (JPC_COUNT_WIDTH)
    ) u_issued_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (handshake),
        .count (issued_count_O)
    );

    assign pc_O       = pc_reg;
    assign pc_valid_O = valid_reg;
    assign epoch_O    = epoch_reg;
    assign misalign_O = misalign_reg;

endmodule

// File: tb/tb_jpc_pcgen.sv
// Scoreboarded bench for jpc_pcgen: directed scenarios then random traffic,
// checked every cycle against an abstract fetch-address model.
module tb_jpc_pcgen;

    logic        clk;
    logic        rst;
    logic [31:0] pc_O;
    logic        pc_valid_O;
    logic        pc_ready_I;
    logic [1:0]  epoch_O;
    logic        redirect_valid_I;
    logic [31:0] redirect_pc_I;
    logic        halt_I;
    logic        misalign_O;
    logic [31:0] issued_count_O;

    jpc_pcgen #(
        .ADDR_WIDTH  (32),
        .RESET_PC    (32'h0),
        .PC_STEP     (4),
        .EPOCH_WIDTH (2)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .pc_O             (pc_O),
        .pc_valid_O       (pc_valid_O),
        .pc_ready_I       (pc_ready_I),
        .epoch_O          (epoch_O),
        .redirect_valid_I (redirect_valid_I),
        .redirect_pc_I    (redirect_pc_I),
        .halt_I           (halt_I),
        .misalign_O       (misalign_O),
        .issued_count_O   (issued_count_O)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [1:0]  epoch;
        logic        mis;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: what the fetch channel should look like after each edge.
    logic        m_valid = 1'b0;
    logic [31:0] m_pc    = 32'h0;
    logic [1:0]  m_epoch = 2'd0;
    logic        m_fault = 1'b0;
    logic [31:0] m_cnt   = 32'h0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s at %0t: got=%h want=%h", name, $time, got, want);
        end
    endtask

    task automatic model_edge(input logic r, input logic rdy, input logic rv,
                              input logic [31:0] rpc, input logic h);
        logic accepted;
        if (r) begin
            m_valid = 1'b0;
            m_pc    = 32'h0;
            m_epoch = 2'd0;
            m_fault = 1'b0;
            m_cnt   = 32'h0;
        end else begin
            accepted = m_valid && rdy;
            if (accepted) m_cnt = m_cnt + 1;
            if (!m_fault && rv) begin
                m_pc    = rpc;
                m_epoch = m_epoch + 2'd1;
                if (rpc % 4 != 0) m_fault = 1'b1;
            end else if (accepted) begin
                m_pc = m_pc + 4;
            end
            m_valid = !m_fault && !h;
        end
    endtask

    task automatic step(input logic r, input logic rdy, input logic rv,
                        input logic [31:0] rpc, input logic h, input bit verbose);
        exp_t e;
        @(negedge clk);
        rst              = r;
        pc_ready_I       = rdy;
        redirect_valid_I = rv;
        redirect_pc_I    = rpc;
        halt_I           = h;
        model_edge(r, rdy, rv, rpc, h);
        e.valid = m_valid;
        e.pc    = m_pc;
        e.epoch = m_epoch;
        e.mis   = m_fault;
        e.cnt   = m_cnt;
        exp_q.push_back(e);
        if (verbose)
            $display("txn rst=%0b rdy=%0b redir=%0b->%h halt=%0b | expect valid=%0b pc=%h epoch=%0d mis=%0b cnt=%0d",
                     r, rdy, rv, rpc, h, e.valid, e.pc, e.epoch, e.mis, e.cnt);
    endtask

    // Monitor: compares the DUT against the oldest queued expectation each cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("pc_valid", {31'b0, pc_valid_O}, {31'b0, e.valid});
                check("pc", pc_O, e.pc);
                check("epoch", {30'b0, epoch_O}, {30'b0, e.epoch});
                check("misalign", {31'b0, misalign_O}, {31'b0, e.mis});
                check("issued_count", issued_count_O, e.cnt);
            end
        end
    end

    initial begin
        logic        h_level;
        logic        rv;
        logic [31:0] tgt;
        rst = 1'b1; pc_ready_I = 1'b0; redirect_valid_I = 1'b0;
        redirect_pc_I = '0; halt_I = 1'b0;

        // Reset, BOOT cycle, first offer at 0x0 epoch 0.
        step(1, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        // Accept 0x0 and 0x4, stall 3 cycles on 0x8, then accept 0x8 and 0xC.
        step(0, 1, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 1);
        // Handshake of 0x10 with a simultaneous redirect to 0x40.
        step(0, 1, 1, 32'h40, 0, 1);
        // Three more redirects: epoch wraps to 0, ending at 0x44.
        step(0, 0, 1, 32'h48, 0, 1);
        step(0, 0, 1, 32'h4C, 0, 1);
        step(0, 0, 1, 32'h44, 0, 1);
        // Halt two cycles at 0x44 with a redirect to 0x80 during the halt.
        step(0, 0, 0, 0, 1, 1);
        step(0, 0, 1, 32'h80, 1, 1);
        step(0, 0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 1);
        // Misaligned redirect, then redirects and halt toggles are ignored.
        step(0, 1, 1, 32'h42, 0, 1);
        step(0, 1, 1, 32'h100, 0, 1);
        step(0, 1, 0, 0, 1, 1);
        step(0, 1, 0, 0, 0, 1);
        step(0, 1, 1, 32'h200, 1, 1);
        // Reset clears the fault; a redirect in the reset cycle is dropped.
        step(1, 1, 1, 32'h300, 0, 1);
        step(0, 1, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 1);

        // Random traffic.
        h_level = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 9) == 0) h_level = ~h_level;
            rv  = ($urandom_range(0, 7) == 0);
            tgt = $urandom & 32'hFFFF_FFFC;
            if (rv && $urandom_range(0, 40) == 0) tgt = tgt | 32'($urandom_range(1, 3));
            step(($urandom_range(0, 150) == 0), ($urandom_range(0, 9) < 7), rv, tgt, h_level, 0);
        end

        step(0, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        #2;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
